// File: rtl/sram_march_ctrl.sv
// March C- style SRAM self-test controller: W0, R0W1 (up), R1W0 (down), R0 (up).
// Reads are compared in the cycle after issue; a miscompare drops the pending write and stops.
module sram_march_ctrl #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] PATTERN = 32'h5555_5555
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            status,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [DATA_W-1:0]     fail_data,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [DATA_W/8-1:0]   sram_wmask,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_din,
  input  logic [DATA_W-1:0]     sram_dout
);

  localparam logic [ADDR_W-1:0]   ADDR_MAX  = '1;
  localparam logic [DATA_W/8-1:0] WMASK_ALL = '1;
  localparam logic [DATA_W-1:0]   BG0       = PATTERN;
  localparam logic [DATA_W-1:0]   BG1       = ~PATTERN;

  localparam logic [7:0] ST_START = 8'h00;
  localparam logic [7:0] ST_W0    = 8'h0A;
  localparam logic [7:0] ST_R0W1  = 8'h14;
  localparam logic [7:0] ST_R1W0  = 8'h1E;
  localparam logic [7:0] ST_R0    = 8'h28;
  localparam logic [7:0] ST_DONE  = 8'hFF;
  localparam logic [7:0] ST_FAIL  = 8'hEE;

  typedef enum logic [2:0] {
    IDLE, W0, R0W1, R1W0, R0, DONE, FAIL
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              cmp_p1;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] step_addr;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] wr_data;
  logic [7:0]        elem_status;
  logic              last_addr;

  // Per-element background, direction and successor for the read/compare elements.
  always_comb begin
    exp_data    = BG0;
    wr_data     = BG1;
    last_addr   = (addr_cnt == ADDR_MAX);
    next_state  = R1W0;
    next_addr   = ADDR_MAX;
    step_addr   = addr_cnt + 1'b1;
    elem_status = ST_R0W1;
    case (state)
      R1W0: begin
        exp_data    = BG1;
        wr_data     = BG0;
        last_addr   = (addr_cnt == '0);
        next_state  = R0;
        next_addr   = '0;
        step_addr   = addr_cnt - 1'b1;
        elem_status = ST_R1W0;
      end
      R0: begin
        next_state  = DONE;
        next_addr   = '0;
        elem_status = ST_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state      <= IDLE;
      cmp_p1     <= 1'b0;
      addr_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      status     <= ST_START;
      fail_addr  <= '0;
      fail_data  <= '0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
    end else begin
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_wmask <= '0;
      case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            state     <= W0;
            cmp_p1    <= 1'b0;
            addr_cnt  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            status    <= ST_START;
            fail_addr <= '0;
            fail_data <= '0;
          end
        end
        W0: begin
          sram_csb   <= 1'b0;
          sram_web   <= 1'b0;
          sram_wmask <= WMASK_ALL;
          sram_addr  <= addr_cnt;
          sram_din   <= BG0;
          if (addr_cnt == ADDR_MAX) begin
            state    <= R0W1;
            addr_cnt <= '0;
            status   <= ST_W0;
          end else begin
            addr_cnt <= addr_cnt + 1'b1;
          end
        end
        R0W1, R1W0, R0: begin
          if (!cmp_p1) begin
            // Stage p0: issue the read; data returns while cmp_p1 is high.
            sram_csb  <= 1'b0;
            sram_addr <= addr_cnt;
            cmp_p1    <= 1'b1;
            if (state == R0 && last_addr)
              status <= ST_R0;
          end else begin
            // Stage p1: compare returned data, then schedule the write-back.
            cmp_p1 <= 1'b0;
            if (sram_dout != exp_data) begin
              state     <= FAIL;
              fail_addr <= addr_cnt;
              fail_data <= sram_dout;
              status    <= ST_FAIL;
              done      <= 1'b1;
              pass      <= 1'b0;
              busy      <= 1'b0;
            end else begin
              if (state != R0) begin
                sram_csb   <= 1'b0;
                sram_web   <= 1'b0;
                sram_wmask <= WMASK_ALL;
                sram_addr  <= addr_cnt;
                sram_din   <= wr_data;
              end
              if (last_addr) begin
                state    <= next_state;
                addr_cnt <= next_addr;
                status   <= elem_status;
                if (state == R0) begin
                  done <= 1'b1;
                  pass <= 1'b1;
                  busy <= 1'b0;
                end
              end else begin
                addr_cnt <= step_addr;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_march_ctrl.md
SRAM_MARCH_CTRL -- requirements
Module: sram_march_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, SRAM address width; depth is 2^ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM word width, multiple of 8.
REQ-003 SHALL have parameter PATTERN, default 32'h5555_5555, the "0" background; the "1" background is ~PATTERN.
REQ-004 SHALL have port: clock  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port: resetb  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port: start  in  1  single-cycle request to run the march test.
REQ-007 SHALL have port: busy  out  1  test in progress.
REQ-008 SHALL have port: done  out  1  test finished; held until the next accepted start.
REQ-009 SHALL have port: pass  out  1  valid while done=1; 1 means no miscompare.
REQ-010 SHALL have port: status  out  8  progress/result code.
REQ-011 SHALL have port: fail_addr  out  ADDR_W  address of the first miscompare.
REQ-012 SHALL have port: fail_data  out  DATA_W  data read at the first miscompare.
REQ-013 SHALL have ports: sram_csb, sram_web  out  1 each  SRAM chip select and write enable, both active-low.
REQ-014 SHALL have ports: sram_wmask  out  DATA_W/8  byte mask; sram_addr  out  ADDR_W; sram_din  out  DATA_W.
REQ-015 SHALL have port: sram_dout  in  DATA_W  read data, valid in the cycle after the read is issued.

Function
REQ-016 SHALL implement states IDLE, W0, R0W1, R1W0, R0, DONE, FAIL.
REQ-017 SHALL accept start only in IDLE, DONE or FAIL; start in any other state SHALL be ignored.
REQ-018 On an accepted start: enter W0 on the next edge; clear done, pass, fail_addr, fail_data; set status=8'h00 and busy=1.
REQ-019 W0 SHALL write PATTERN to addresses 0 to max in ascending order, one write per cycle.
REQ-020 R0W1 SHALL process addresses in ascending order, 2 cycles per address:
- cycle A: issue a read.
- cycle B: compare sram_dout with PATTERN, then write ~PATTERN to the same address.
REQ-021 R1W0 SHALL process addresses in descending order (max to 0), 2 cycles per address:
- cycle A: issue a read.
- cycle B: compare with ~PATTERN, then write PATTERN.
REQ-022 R0 SHALL process addresses in ascending order, 2 cycles per address: read, then compare with PATTERN; no write.
REQ-023 On completion of each element, status SHALL update to: W0 8'h0A, R0W1 8'h14, R1W0 8'h1E, R0 8'h28.
REQ-024 After R0, the block SHALL enter DONE with status=8'hFF, pass=1, done=1, busy=0.
REQ-025 On any miscompare, the block SHALL:
- enter FAIL on the next edge and suppress that cycle's write.
- latch the failing address and read data into fail_addr/fail_data.
- set status=8'hEE, done=1, pass=0, busy=0.
REQ-026 Address counter SHALL be ADDR_W bits wide; element termination SHALL be detected on the last address, with no wrap into a further access.
REQ-027 SRAM outputs SHALL be registered:
- sram_wmask is all ones during writes.
- sram_csb=1 in IDLE/DONE/FAIL and on idle cycles.
- sram_web=0 only on write cycles.
REQ-028 Total run length SHALL be 7*2^ADDR_W cycles from the first W0 cycle to entry into DONE.

Reset
REQ-029 When resetb=0 at a rising edge, the block SHALL enter IDLE regardless of state, including mid-element.
REQ-030 Reset values: busy=0, done=0, pass=0, status=8'h00, fail_addr=0, fail_data=0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
REQ-031 start SHALL be ignored in any cycle where resetb=0.

Verification
REQ-032 ADDR_W=4, fault-free SRAM model, one start pulse -> status steps 00,0A,14,1E,28,FF; done=1 and pass=1 exactly 112 cycles after W0 entry; 16 writes in W0, R1W0 addresses run 15..0.
REQ-033 ADDR_W=4, bit 3 of address 5 stuck at 1 -> FAIL during R0W1; status=8'hEE, fail_addr=5, fail_data=32'h5555_555D, pass=0; no write to address 5 in that cycle.
REQ-034 start pulsed during R0W1 -> ignored; sequence and cycle count identical to REQ-032.
REQ-035 resetb low for one cycle during R1W0 -> next cycle busy=0, status=8'h00, sram_csb=1; a later start runs a complete pass.
REQ-036 start pulsed while in DONE -> done, pass and status clear to 0, 0, 8'h00 on the next edge; full test reruns and passes.
